// File: rtl/debug_ring_scheduler.sv
// debug_ring_scheduler: on a manual or periodic trigger, loads the debug ring once, then shifts N 32-bit words into a FWFT FIFO.
// Latency: accepted trigger at cycle 0 -> busy and first debug_sl=1 at cycle 1; word pushed at t -> rd_valid at t+1.
// Backpressure: a full FIFO parks the sequencer in PUSH with debug_sl=0, so the ring simply pauses between words.
// Ports: mclk / mrst_n          clock, asynchronous active-low reset
//        cfg_we/cfg_addr/cfg_data register writes: 0 ctrl {clr_ovr,cont,en}, 1 period, 2 word count
//        trig                   single-cycle manual trigger (ignored while en=0)
//        debug_do/sl/di         ring wires (do tied low, sl = 0 idle / 1,0 shift / 1,1 load)
//        rd_data/valid/ready    FIFO drain port
//        busy/overrun/frame_cnt status: frame active, sticky dropped trigger, completed frames
module debug_ring_scheduler #(
   parameter int DEBUG_CMD_LATENCY = 2,
   parameter int FIFO_LOG2         = 4,
   parameter int PERIOD_WIDTH      = 16
) (
   input  logic        mclk,
   input  logic        mrst_n,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_addr,
   input  logic [31:0] cfg_data,
   input  logic        trig,
   output logic        debug_do,
   output logic        debug_sl,
   input  logic        debug_di,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   input  logic        rd_ready,
   output logic        busy,
   output logic        overrun,
   output logic [15:0] frame_cnt
);

   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam logic [5:0] DRAIN_LAST = 6'(DEBUG_CMD_LATENCY);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DRAIN, S_PUSH, S_DONE} state_t;

   state_t                  state;
   logic                    en, cont;
   logic [PERIOD_WIDTH-1:0] period_reg, period_act, tmr;
   logic [7:0]              wcount_reg, words_left;
   logic [5:0]              cnt;
   logic                    sl_q;
   logic [DEBUG_CMD_LATENCY:0] pipe;
   logic [31:0]             word;
   logic                    tmr_wrap, fire, any_trig, clr_ovr;
   logic                    push, pop, fifo_full;
   logic [31:0]             mem [DEPTH];
   logic [FIFO_LOG2-1:0]    wptr, rptr;
   logic [FIFO_LOG2:0]      fifo_cnt;
   logic                    unused_cfg;

   assign unused_cfg = ^cfg_data;
   assign debug_do   = 1'b0;
   assign debug_sl   = sl_q;
   assign busy       = (state != S_IDLE);

   // period_act is the period in force for the current timer lap; new writes are picked up at the wrap.
   assign tmr_wrap = (period_act != '0) && (tmr == period_act - PERIOD_WIDTH'(1));
   assign fire     = cont && en && tmr_wrap;
   assign any_trig = (trig && en) || fire;
   assign clr_ovr  = cfg_we && (cfg_addr == 2'd0) && cfg_data[2];

   always_ff @(posedge mclk or negedge mrst_n) begin
      if (!mrst_n) begin
         en         <= 1'b0;
         cont       <= 1'b0;
         period_reg <= '0;
         wcount_reg <= '0;
      end else if (cfg_we) begin
         case (cfg_addr)
            2'd0:    begin en <= cfg_data[0]; cont <= cfg_data[1]; end
            2'd1:    period_reg <= cfg_data[PERIOD_WIDTH-1:0];
            2'd2:    wcount_reg <= cfg_data[7:0];
            default: ;
         endcase
      end
   end

   // Free-running period timer; independent of the sequencer state.
   always_ff @(posedge mclk or negedge mrst_n) begin
      if (!mrst_n) begin
         tmr        <= '0;
         period_act <= '0;
      end else if (period_act == '0 || tmr_wrap) begin
         tmr        <= '0;
         period_act <= period_reg;
      end else begin
         tmr <= tmr + PERIOD_WIDTH'(1);
      end
   end

   // A drop in the same cycle as a clear leaves overrun set: the newer event wins.
   always_ff @(posedge mclk or negedge mrst_n) begin
      if (!mrst_n)               overrun <= 1'b0;
      else if (busy && any_trig) overrun <= 1'b1;
      else if (clr_ovr)          overrun <= 1'b0;
   end

   // Sequencer. debug_sl is registered alongside the state so it is glitch-free on the ring.
   always_ff @(posedge mclk or negedge mrst_n) begin
      if (!mrst_n) begin
         state      <= S_IDLE;
         cnt        <= '0;
         words_left <= '0;
         sl_q       <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: if (any_trig) begin
               state      <= S_LOAD;
               cnt        <= '0;
               sl_q       <= 1'b1;
               words_left <= wcount_reg;
            end
            S_LOAD: begin
               if (cnt == 6'd0) begin
                  cnt <= 6'd1;
               end else if (words_left == 8'd0) begin
                  state     <= S_DONE;
                  sl_q      <= 1'b0;
                  frame_cnt <= frame_cnt + 16'd1;
               end else begin
                  state <= S_SHIFT;
                  cnt   <= '0;
                  sl_q  <= 1'b1;
               end
            end
            S_SHIFT: begin
               // Even cnt cycles carry sl=1, odd ones sl=0: 32 (1,0) pulses in 64 cycles.
               if (cnt == 6'd63) begin
                  state <= S_DRAIN;
                  cnt   <= '0;
                  sl_q  <= 1'b0;
               end else begin
                  cnt  <= cnt + 6'd1;
                  sl_q <= cnt[0];
               end
            end
            S_DRAIN: begin
               if (cnt == DRAIN_LAST) begin
                  state <= S_PUSH;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            S_PUSH: if (!fifo_full) begin
               if (words_left == 8'd1) begin
                  state     <= S_DONE;
                  frame_cnt <= frame_cnt + 16'd1;
               end else begin
                  state      <= S_SHIFT;
                  words_left <= words_left - 8'd1;
                  sl_q       <= 1'b1;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // The ring answers a pulse issued at t with its bit on debug_di at t+LAT+1; pipe tracks that delay.
   always_ff @(posedge mclk or negedge mrst_n) begin
      if (!mrst_n) begin
         pipe <= '0;
         word <= '0;
      end else begin
         pipe <= {pipe[DEBUG_CMD_LATENCY-1:0], (sl_q && state == S_SHIFT)};
         if (pipe[DEBUG_CMD_LATENCY]) word <= {debug_di, word[31:1]};
      end
   end

   // First-word-fall-through FIFO.
   assign fifo_full = (fifo_cnt == (FIFO_LOG2+1)'(DEPTH));
   assign rd_valid  = (fifo_cnt != '0);
   assign rd_data   = mem[rptr];
   assign push      = (state == S_PUSH) && !fifo_full;
   assign pop       = rd_valid && rd_ready;

   always_ff @(posedge mclk) begin
      if (push) mem[wptr] <= word;
   end

   always_ff @(posedge mclk or negedge mrst_n) begin
      if (!mrst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push) wptr <= wptr + FIFO_LOG2'(1);
         if (pop)  rptr <= rptr + FIFO_LOG2'(1);
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + (FIFO_LOG2+1)'(1);
            2'b01:   fifo_cnt <= fifo_cnt - (FIFO_LOG2+1)'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_ring_scheduler.sv
// tb_debug_ring_scheduler: directed bench with a behavioural debug ring and a FIFO-word scoreboard.
// Latency: ring model answers a shift pulse LAT+1 cycles after it is issued, like the real ring.
// Backpressure: rd_ready is driven per test; the monitor only consumes words on rd_valid && rd_ready.
module tb_debug_ring_scheduler;

   localparam int LAT = 2;
   localparam logic [127:0] RING_IMG = {32'h0BADC0DE, 32'hCAFEF00D, 32'h12345678, 32'hDEADBEEF};

   logic        mclk = 1'b0;
   logic        mrst_n = 1'b0;
   logic        cfg_we = 1'b0;
   logic [1:0]  cfg_addr = 2'd0;
   logic [31:0] cfg_data = 32'd0;
   logic        trig = 1'b0;
   logic        rd_ready = 1'b0;
   logic        debug_do, debug_sl, debug_di;
   logic [31:0] rd_data;
   logic        rd_valid, busy, overrun;
   logic [15:0] frame_cnt;

   int          n_checks = 0;
   int          n_pass = 0;
   int          cyc = 0;
   logic [31:0] exp_q [$];

   // Ring model state
   logic [127:0]   chain = '0;
   logic [LAT-1:0] slh;
   logic           pend;
   int             n_loads = 0;
   int             n_shifts = 0;

   debug_ring_scheduler #(
      .DEBUG_CMD_LATENCY(LAT),
      .FIFO_LOG2(1),
      .PERIOD_WIDTH(16)
   ) dut (
      .mclk(mclk), .mrst_n(mrst_n),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .trig(trig),
      .debug_do(debug_do), .debug_sl(debug_sl), .debug_di(debug_di),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
   );

   always #5 mclk = ~mclk;
   always @(posedge mclk) cyc <= cyc + 1;

   // Ring: sees debug_sl LAT cycles late, decodes (1,1)=load and (1,0)=shift, LSB on debug_di.
   assign debug_di = chain[0];
   always @(posedge mclk or negedge mrst_n) begin
      if (!mrst_n) begin
         slh  <= '0;
         pend <= 1'b0;
      end else begin
         slh <= {slh[LAT-2:0], debug_sl};
         if (!pend) begin
            if (slh[LAT-1]) pend <= 1'b1;
         end else begin
            pend <= 1'b0;
            if (slh[LAT-1]) begin
               chain   <= RING_IMG;
               n_loads <= n_loads + 1;
            end else begin
               chain    <= {debug_do, chain[127:1]};
               n_shifts <= n_shifts + 1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   // Scoreboard monitor: each word the DUT hands over is compared with the oldest expected word.
   always @(negedge mclk) begin
      if (mrst_n && rd_valid && rd_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_word: got 0x%0h, want no word", rd_data);
         end else begin
            check("fifo_word", rd_data, exp_q.pop_front());
         end
      end
   end

   task automatic cycle();
      @(posedge mclk);
      #1;
   endtask

   task automatic do_reset();
      mrst_n = 1'b0;
      cfg_we = 1'b0;
      trig   = 1'b0;
      repeat (3) @(posedge mclk);
      #1 mrst_n = 1'b1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      cycle();
      cfg_we   = 1'b0;
   endtask

   task automatic pulse_trig();
      trig = 1'b1;
      cycle();
      trig = 1'b0;
   endtask

   // Called in cycle 1 of a frame; n ends as the cycle at which busy is low again.
   task automatic run_to_idle(input int lim, output int n);
      n = 1;
      while (busy && n < lim) begin
         cycle();
         n++;
      end
      check("idle_reached", busy, 1'b0);
   endtask

   task automatic wait_busy_rise(input int lim, output int at);
      int n = 0;
      while (!busy && n < lim) begin
         cycle();
         n++;
      end
      at = cyc;
      check("busy_rise_seen", busy, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   initial begin
      int d, s0, s1, b_ld, b_sh, hi;

      // Reset values
      do_reset();
      check("rst_busy", busy, 1'b0);
      check("rst_debug_sl", debug_sl, 1'b0);
      check("rst_debug_do", debug_do, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      check("rst_frame_cnt", frame_cnt, 16'd0);

      // Single trigger, 2 words
      rd_ready = 1'b1;
      cfg_write(2'd2, 32'd2);
      cfg_write(2'd0, 32'd1);
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'h12345678);
      b_ld = n_loads; b_sh = n_shifts;
      pulse_trig();
      check("t1_busy_cycle1", busy, 1'b1);
      check("t1_sl_cycle1", debug_sl, 1'b1);
      run_to_idle(400, d);
      check("t1_duration", d, 32'd140);
      repeat (4) cycle();
      check("t1_loads", n_loads - b_ld, 32'd1);
      check("t1_shifts", n_shifts - b_sh, 32'd64);
      check("t1_frame_cnt", frame_cnt, 16'd1);
      check("t1_words_left", exp_q.size(), 32'd0);

      // Zero word count
      do_reset();
      rd_ready = 1'b1;
      cfg_write(2'd2, 32'd0);
      cfg_write(2'd0, 32'd1);
      b_ld = n_loads; b_sh = n_shifts;
      pulse_trig();
      run_to_idle(100, d);
      check("t2_duration", d, 32'd4);
      repeat (4) cycle();
      check("t2_loads", n_loads - b_ld, 32'd1);
      check("t2_shifts", n_shifts - b_sh, 32'd0);
      check("t2_rd_valid", rd_valid, 1'b0);
      check("t2_frame_cnt", frame_cnt, 16'd1);

      // Periodic mode: 140-cycle frames on a 100-cycle period drop every second fire
      do_reset();
      rd_ready = 1'b1;
      repeat (2) begin
         exp_q.push_back(32'hDEADBEEF);
         exp_q.push_back(32'h12345678);
      end
      cfg_write(2'd2, 32'd2);
      cfg_write(2'd1, 32'd100);
      cfg_write(2'd0, 32'd3);
      wait_busy_rise(400, s0);
      run_to_idle(400, d);
      check("t3_duration", d, 32'd140);
      wait_busy_rise(400, s1);
      check("t3_start_gap", s1 - s0, 32'd200);
      check("t3_overrun_set", overrun, 1'b1);
      cfg_write(2'd0, 32'd0);
      run_to_idle(400, d);
      check("t3_frame_cnt", frame_cnt, 16'd2);
      repeat (250) cycle();
      check("t3_stopped_frame_cnt", frame_cnt, 16'd2);
      check("t3_words_left", exp_q.size(), 32'd0);
      cfg_write(2'd0, 32'd4);
      check("t3_overrun_cleared", overrun, 1'b0);

      // FIFO backpressure with a 2-deep FIFO and 4 words
      do_reset();
      rd_ready = 1'b0;
      cfg_write(2'd2, 32'd4);
      cfg_write(2'd0, 32'd1);
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'h12345678);
      exp_q.push_back(32'hCAFEF00D);
      exp_q.push_back(32'h0BADC0DE);
      b_sh = n_shifts;
      pulse_trig();
      repeat (400) cycle();
      check("t4_stall_busy", busy, 1'b1);
      check("t4_stall_sl", debug_sl, 1'b0);
      check("t4_stall_rd_valid", rd_valid, 1'b1);
      check("t4_stall_frame_cnt", frame_cnt, 16'd0);
      check("t4_stall_shifts", n_shifts - b_sh, 32'd96);
      hi = 0;
      repeat (20) begin
         cycle();
         hi += int'(debug_sl);
      end
      check("t4_stall_sl_window", hi, 32'd0);
      rd_ready = 1'b1;
      run_to_idle(1000, d);
      repeat (4) cycle();
      check("t4_frame_cnt", frame_cnt, 16'd1);
      check("t4_shifts", n_shifts - b_sh, 32'd128);
      check("t4_words_left", exp_q.size(), 32'd0);

      // Reset in the middle of SHIFT, then a clean frame
      do_reset();
      rd_ready = 1'b1;
      cfg_write(2'd2, 32'd2);
      cfg_write(2'd0, 32'd1);
      pulse_trig();
      repeat (30) cycle();
      mrst_n = 1'b0;
      #1;
      check("t5_rst_busy", busy, 1'b0);
      check("t5_rst_sl", debug_sl, 1'b0);
      check("t5_rst_rd_valid", rd_valid, 1'b0);
      check("t5_rst_frame_cnt", frame_cnt, 16'd0);
      cycle();
      mrst_n = 1'b1;
      cfg_write(2'd2, 32'd2);
      cfg_write(2'd0, 32'd1);
      exp_q.push_back(32'hDEADBEEF);
      exp_q.push_back(32'h12345678);
      b_ld = n_loads; b_sh = n_shifts;
      pulse_trig();
      run_to_idle(400, d);
      check("t5_duration", d, 32'd140);
      repeat (4) cycle();
      check("t5_frame_cnt", frame_cnt, 16'd1);
      check("t5_loads", n_loads - b_ld, 32'd1);
      check("t5_shifts", n_shifts - b_sh, 32'd64);

      // Enable gating
      do_reset();
      rd_ready = 1'b1;
      cfg_write(2'd2, 32'd1);
      cfg_write(2'd0, 32'd0);
      b_ld = n_loads; b_sh = n_shifts;
      pulse_trig();
      repeat (20) cycle();
      check("t6_gated_busy", busy, 1'b0);
      check("t6_gated_loads", n_loads - b_ld, 32'd0);
      check("t6_gated_frame_cnt", frame_cnt, 16'd0);
      cfg_write(2'd0, 32'd1);
      exp_q.push_back(32'hDEADBEEF);
      b_sh = n_shifts;
      pulse_trig();
      repeat (10) cycle();
      cfg_write(2'd0, 32'd0);
      check("t6_busy_after_disable", busy, 1'b1);
      run_to_idle(400, d);
      repeat (4) cycle();
      check("t6_frame_cnt", frame_cnt, 16'd1);
      check("t6_shifts", n_shifts - b_sh, 32'd32);

      repeat (5) cycle();
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
